// File: rtl/comm_wr_adr.sv
// comm_wr_adr: receiver-to-buffer write sequencer with double-banked frames.
// Ports: clk, rst (async high); wrVal/wrData word strobe in; rdDone1/2 bank
//   release from reader; WR/WrAdr/WrData/WrBank buffer write; strob1/2 bank
//   full; busy = FSM not idle; ovfCnt (only with WR_OVF_EN) counts drops.
module comm_wr_adr #(
  parameter int FRAME_LEN = 18,
  parameter int WR_PULSE  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrVal,
  input  logic [15:0] wrData,
  input  logic        rdDone1,
  input  logic        rdDone2,
  output logic        WR,
  output logic [4:0]  WrAdr,
  output logic [15:0] WrData,
  output logic        WrBank,
  output logic        strob1,
  output logic        strob2,
`ifdef WR_OVF_EN
  output logic [7:0]  ovfCnt,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRSET = 2'd1,
    CNT   = 2'd2
  } state_t;

  localparam logic [3:0] PULSE_LAST = 4'(WR_PULSE - 1);
  localparam logic [4:0] ADR_LAST   = 5'(FRAME_LEN - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [4:0]  adr_q, adr_d;
  logic [15:0] data_q, data_d;
  logic        bank_q, bank_d;
  logic [1:0]  full_q, full_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    adr_d   = adr_q;
    data_d  = data_q;
    bank_d  = bank_q;
    full_d  = full_q;
    // Release only applies to a bank that is actually full.
    if (rdDone1 && full_q[0]) full_d[0] = 1'b0;
    if (rdDone2 && full_q[1]) full_d[1] = 1'b0;
    case (state_q)
      IDLE: begin
        // Full check uses the registered flag, so a same-cycle
        // release does not rescue this word.
        if (wrVal && !full_q[bank_q]) begin
          data_d  = wrData;
          wr_d    = 1'b1;
          cnt_d   = 4'd0;
          state_d = WRSET;
        end
      end
      WRSET: begin
        if (cnt_q == PULSE_LAST) begin
          wr_d    = 1'b0;
          state_d = CNT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CNT: begin
        if (adr_q == ADR_LAST) begin
          adr_d          = 5'd0;
          full_d[bank_q] = 1'b1;
          bank_d         = ~bank_q;
        end else begin
          adr_d = adr_q + 5'd1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      adr_q   <= 5'd0;
      data_q  <= 16'd0;
      bank_q  <= 1'b0;
      full_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
      bank_q  <= bank_d;
      full_q  <= full_d;
    end
  end

`ifdef WR_OVF_EN
  logic       drop;
  logic [7:0] ovf_q, ovf_d;

  always_comb begin
    drop  = wrVal && !((state_q == IDLE) && !full_q[bank_q]);
    ovf_d = ovf_q;
    if (drop && (ovf_q != 8'hff)) ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 8'd0;
    else     ovf_q <= ovf_d;
  end

  assign ovfCnt = ovf_q;
`endif

  assign WR     = wr_q;
  assign WrAdr  = adr_q;
  assign WrData = data_q;
  assign WrBank = bank_q;
  assign strob1 = full_q[0];
  assign strob2 = full_q[1];
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_comm_wr_adr.sv
// tb_comm_wr_adr: scoreboard bench for comm_wr_adr.
// Expected writes are queued at stimulus time and popped on each WR pulse.
module tb_comm_wr_adr;

  localparam int WR_PULSE  = 4;
  localparam int FRAME_LEN = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wrVal = 1'b0;
  logic [15:0] wrData = 16'd0;
  logic        rdDone1 = 1'b0;
  logic        rdDone2 = 1'b0;
  logic        WR;
  logic [4:0]  WrAdr;
  logic [15:0] WrData;
  logic        WrBank;
  logic        strob1;
  logic        strob2;
  logic        busy;
`ifdef WR_OVF_EN
  logic [7:0]  ovfCnt;
`endif

  comm_wr_adr #(
    .FRAME_LEN(FRAME_LEN),
    .WR_PULSE (WR_PULSE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wrVal  (wrVal),
    .wrData (wrData),
    .rdDone1(rdDone1),
    .rdDone2(rdDone2),
    .WR     (WR),
    .WrAdr  (WrAdr),
    .WrData (WrData),
    .WrBank (WrBank),
    .strob1 (strob1),
    .strob2 (strob2),
`ifdef WR_OVF_EN
    .ovfCnt (ovfCnt),
`endif
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  adr;
    logic [15:0] data;
    logic        bank;
  } wr_t;

  wr_t q[$];
  int  n_err = 0;
  int  n_chk = 0;

  logic [4:0] m_adr = 5'd0;
  logic       m_bank = 1'b0;
  logic [1:0] m_full = 2'b00;
  int         m_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [15:0] d, input bit acc);
    wr_t e;
    wrVal  = 1'b1;
    wrData = d;
    if (acc) begin
      e.adr  = m_adr;
      e.data = d;
      e.bank = m_bank;
      q.push_back(e);
      if (m_adr == 5'(FRAME_LEN - 1)) begin
        m_adr          = 5'd0;
        m_full[m_bank] = 1'b1;
        m_bank         = ~m_bank;
      end else begin
        m_adr = m_adr + 5'd1;
      end
    end else begin
      m_ovf++;
    end
    tick();
    wrVal = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_adr"}, WrAdr, m_adr);
    chk({tag, "_bank"}, WrBank, m_bank);
    chk({tag, "_s1"}, strob1, m_full[0]);
    chk({tag, "_s2"}, strob2, m_full[1]);
    chk({tag, "_busy"}, busy, 0);
`ifdef WR_OVF_EN
    chk({tag, "_ovf"}, ovfCnt, m_ovf);
`endif
  endtask

  // WR pulse monitor, sampled on the falling edge.
  logic wr_prev = 1'b0;
  int   width = 0;
  wr_t  cur;

  always @(negedge clk) begin
    if (rst) begin
      wr_prev = 1'b0;
      width   = 0;
    end else begin
      if (WR && !wr_prev) begin
        chk("wr_q", q.size() > 0, 1);
        if (q.size() > 0) begin
          cur = q.pop_front();
          chk("wr_adr", WrAdr, cur.adr);
          chk("wr_data", WrData, cur.data);
          chk("wr_bank", WrBank, cur.bank);
        end
        width = 1;
      end else if (WR) begin
        width++;
        chk("hold_adr", WrAdr, cur.adr);
        chk("hold_data", WrData, cur.data);
      end else if (wr_prev) begin
        chk("wr_width", width, WR_PULSE);
      end
      wr_prev = WR;
    end
  end

  initial begin
    idle(2);
    chk("rst_wr", WR, 0);
    chk("rst_data", WrData, 0);
    chk_state("rst");
    rst = 1'b0;
    idle(2);

    // One full frame into bank 0.
    for (int i = 0; i < FRAME_LEN; i++) begin
      send(16'h0100 + 16'(i), 1'b1);
      idle(9);
    end
    drain();
    chk_state("frame0");
    chk("frame0_s1", strob1, 1);
    chk("frame0_bank", WrBank, 1);

    // Second frame fills bank 1, then a word with both banks full.
    for (int i = 0; i < FRAME_LEN; i++) begin
      send(16'h0200 + 16'(i), 1'b1);
      idle(9);
    end
    drain();
    send(16'hdead, 1'b0);
    idle(9);
    chk_state("both_full");
    chk("both_q", q.size(), 0);

    // Release of bank 0 coincident with a word: word still dropped.
    rdDone1 = 1'b1;
    send(16'hbeef, 1'b0);
    rdDone1 = 1'b0;
    m_full[0] = 1'b0;
    chk("rel_s1", strob1, 0);
    chk("rel_s2", strob2, 1);
    idle(2);
    chk_state("rel");

    // Bank 0 writable again from address 0.
    send(16'h0300, 1'b1);
    idle(9);
    chk_state("after_rel");

    // A word two cycles after an accepted one is dropped.
    send(16'h0400, 1'b1);
    idle(1);
    send(16'h0401, 1'b0);
    idle(9);
    chk_state("close");

    // rdDone1 for a bank that is not full is ignored; rdDone2 releases.
    rdDone1 = 1'b1;
    rdDone2 = 1'b1;
    tick();
    rdDone1 = 1'b0;
    rdDone2 = 1'b0;
    m_full[1] = 1'b0;
    chk_state("rd2");

    // Advance to address 5, then reset inside the pulse.
    send(16'h0500, 1'b1);
    idle(9);
    send(16'h0501, 1'b1);
    idle(9);
    send(16'h0502, 1'b1);
    idle(9);
    chk("pre_rst_adr", WrAdr, 5);
    send(16'h0503, 1'b1);
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_wr", WR, 0);
    chk("mid_adr", WrAdr, 0);
    chk("mid_busy", busy, 0);
    chk("mid_data", WrData, 0);
    m_adr  = 5'd0;
    m_bank = 1'b0;
    m_full = 2'b00;
    m_ovf  = 0;
    idle(2);
    rst = 1'b0;
    idle(2);
    chk_state("post_rst");
    send(16'h0600, 1'b1);
    idle(9);
    drain();
    chk_state("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/comm_wr_adr.md
COMM_WR_ADR -- requirements
Module: comm_wr_adr

Interface
REQ-001 Parameter FRAME_LEN, default 18: words per frame and per bank.
REQ-002 Parameter WR_PULSE, default 4: WR pulse width in clk cycles; legal range 1..15.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wrVal  input  1  one-cycle word strobe from the receiver; there is no backpressure.
REQ-006 wrData  input  16  word qualified by wrVal.
REQ-007 rdDone1, rdDone2  input  1 each  one-cycle pulses from the reader marking bank 0 or bank 1 consumed.
REQ-008 WR  output  1  buffer write-enable pulse.
REQ-009 WrAdr  output  5  buffer word address, 0..FRAME_LEN-1.
REQ-010 WrData  output  16  latched word to write.
REQ-011 WrBank  output  1  bank currently being filled.
REQ-012 strob1, strob2  output  1 each  bank 0 or bank 1 full; this is the strobe seen by the reader sequencer.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, WRSET and CNT.
REQ-015 IDLE, wrVal=1 and the current bank not full:
- WrData <= wrData.
- WR <= 1.
- Pulse counter <= 0.
- Next state WRSET.
REQ-016 WRSET: the pulse counter SHALL increment each cycle; when it equals WR_PULSE-1, WR <= 0 and the FSM SHALL go to CNT.
REQ-017 CNT:
- If WrAdr==FRAME_LEN-1: WrAdr <= 0, full flag of WrBank <= 1, WrBank toggles.
- Otherwise WrAdr increments.
- Next state IDLE.
REQ-018 Timing: a word strobed in cycle N SHALL have WrData valid from N+1, WR high for cycles N+1..N+WR_PULSE, and the FSM back in IDLE at N+WR_PULSE+2.
REQ-019 WrAdr and WrData SHALL stay stable throughout the WR pulse.
REQ-020 A word SHALL be dropped, with no state change, if wrVal arrives outside IDLE or while the current bank is full.
REQ-021 strob1 SHALL equal the bank-0 full flag and strob2 the bank-1 full flag; each flag stays high until its rdDone pulse.
REQ-022 rdDone1 SHALL clear the bank-0 flag, and rdDone2 the bank-1 flag, in the cycle after the pulse.
REQ-023 An rdDone pulse for a bank that is not full SHALL be ignored.
REQ-024 If an rdDone pulse for the current bank arrives in the same cycle as a wrVal that is dropped for bank-full, the word SHALL still be dropped; the bank becomes writable from the next cycle.
REQ-025 If both banks are full, the FSM SHALL remain in IDLE and drop every incoming word.
REQ-026 WrAdr SHALL never exceed FRAME_LEN-1; wrap to 0 occurs only in CNT.

Reset
REQ-027 While rst=1, all of the following SHALL be forced to zero immediately: WR, WrAdr, WrData, WrBank, strob1, strob2, busy, the pulse counter and the full flags; the FSM SHALL be in IDLE.
REQ-028 A reset mid-frame or mid-pulse SHALL discard the partial frame; WR falls asynchronously.

Configuration
REQ-029 With WR_OVF_EN defined:
- An extra output ovfCnt, 8 bits, SHALL count dropped words.
- The count saturates at 255 and is cleared by reset.
REQ-030 Without WR_OVF_EN, the ovfCnt port and its counter SHALL be absent; drops are silent and all other behaviour is identical.

Verification
REQ-031 Reset, then 18 wrVal pulses 10 cycles apart, values 0x0100..0x0111 -> 18 WR pulses, each 4 cycles wide, on WrAdr 0..17 with matching WrData; strob1=1 after the last CNT; WrBank=1.
REQ-032 Fill both banks (36 words) with no rdDone, then send a 37th word -> no WR pulse, strob1=strob2=1; with WR_OVF_EN, ovfCnt=1.
REQ-033 A second wrVal 2 cycles after an accepted one (WR_PULSE=4) -> dropped; WrAdr advances by 1 only.
REQ-034 Both banks full, rdDone1 pulse, then a word -> strob1=0 the next cycle; the word is written to bank 0 at WrAdr 0.
REQ-035 Assert rst during the 3rd cycle of WR at WrAdr=5 -> WR, WrAdr and busy go to 0 at once; after release, the next word goes to WrAdr 0, bank 0.
